regfile_hazard_ctrl: RTL and testbench
======================================

Name: regfile_hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage CPU built around the 2-read/1-write register file.
- Tracks destination-register state for EX/MEM/WB in an internal shadow pipeline, generates forwarding selects for both read ports, and stalls ID on load-use hazards and memory wait.
- Drives the register file write port (we/wn) from its WB entry.

Parameters:
AW, 5, register-number width (32 architectural registers, r0 hard-wired zero)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
id_valid  input  1  ID stage holds a real instruction
id_rs  input  AW  ID source A register number
id_rt  input  AW  ID source B register number
id_use_rs  input  1  instruction reads rs
id_use_rt  input  1  instruction reads rt
id_wreg  input  1  instruction writes a register
id_wn  input  AW  destination register number
id_m2reg  input  1  instruction is a load
flush  input  1  kill ID instruction (taken branch/jump)
mem_wait  input  1  data memory not ready, MEM must hold
stall  output  1  freeze PC and IF/ID register
fwda  output  2  port-A operand select
fwdb  output  2  port-B operand select
rf_we  output  1  register file write enable
rf_wn  output  AW  register file write number

Behaviour:
- Reset is asynchronous and active-low on rst_n; single clock clk.
- Stage entry = {valid, wreg, m2reg, wn}. Three entries: EX, MEM, WB.
- Reset values: all entries 0, kill_pend=0. Outputs: stall=0, fwda=fwdb=00, rf_we=0, rf_wn=0.
- Forward codes: 00 regfile, 01 EX ALU result, 10 MEM result (ALU or load data), 11 WB result.
- Operand X (rs or rt) matches stage S when all hold: use_X, S.valid, S.wreg, S.wn==X, and X!=0.
- fwd priority: EX > MEM > WB > regfile. With use_X=0 or X==0, fwd=00. An EX match on a load (EX.m2reg) does not forward.
- lu_hazard = id_valid & !flush & !kill_pend & (rs or rt matches EX with EX.m2reg=1).
- stall = lu_hazard | mem_wait (combinational).
- rf_we = WB.valid & WB.wreg & (WB.wn!=0); rf_wn = WB.wn. Both come from registered state, with no combinational path from inputs.
- Per clock, exactly one case applies, in priority order:
  - mem_wait=1: EX and MEM hold; WB <= bubble; ID held. If flush=1 then kill_pend <= 1.
  - lu_hazard=1: EX <= bubble; MEM <= EX; WB <= MEM; ID held.
  - otherwise: EX <= ID entry, with valid = id_valid & !flush & !kill_pend; MEM <= EX; WB <= MEM. kill_pend <= 0.
- Flush during a load-use stall: the ID instruction is killed, the bubble still enters EX, and stall drops the next cycle.
- A MEM-stage load forwards only when mem_wait=0. During mem_wait, fwd outputs are still computed but the datapath ignores them.
- Reset asserted mid-operation: all entries invalidate immediately, so rf_we drops asynchronously.

Optional Feature:
- Macro: REGFILE_HAZARD_STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt, 32 bits, reset 0.
  - Increments on every clock where stall=1, for either cause.
  - Saturates at 0xFFFFFFFF.
- Undefined: the port and counter are absent. All other behaviour is identical.

Decomposition:
- Shared package/header holds:
  - forward-code constants FWD_RF=2'b00, FWD_EX=2'b01, FWD_MEM=2'b10, FWD_WB=2'b11
  - the stage-entry field layout/typedef {valid, wreg, m2reg, wn[AW-1:0]}
  - the stage-entry width constant
- One sub-module, hazard_fwd_sel: combinational per-operand match/priority encoder that outputs a 2-bit fwd code and a load-use flag. Instantiated twice, for rs and rt.

Test Plan:
- ALU back-to-back: issue add r3 (wreg, wn=3), then sub reading rs=3 -> fwda=01 on the second instruction's ID cycle; one cycle later fwda would be 10; rf_we=1, rf_wn=3 three cycles after issue.
- Load-use: lw r5, then add rt=5 -> stall=1 for exactly 1 cycle, bubble in EX, then fwdb=10; no stall if rt=5 arrives two instructions later (fwdb=10, no stall).
- r0 filter: instruction writes wn=0, next reads rs=0 -> fwda=00, stall=0, rf_we=0 when it reaches WB.
- mem_wait for 3 cycles with lw in MEM -> stall=1 for 3 cycles, EX/MEM unchanged, WB receives bubbles (rf_we=0 after the first), pipeline resumes intact.
- Flush asserted during mem_wait -> kill_pend set; the ID instruction does not enter EX (never produces rf_we), kill_pend clears on advance.
- With REGFILE_HAZARD_STALL_CNT_EN: the above sequence gives stall_cnt=1 after the load-use case, +3 after the mem_wait case. An async reset mid-sequence clears it to 0 and rf_we to 0 immediately.

Source files
------------

// File: rtl/regfile_hazard_ctrl_pkg.sv
// rtl/regfile_hazard_ctrl_pkg.sv - shared forward codes and shadow-pipeline stage entry layout
package regfile_hazard_ctrl_pkg;

  localparam int RF_AW = 5;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b11;

  typedef struct packed {
    logic             valid;
    logic             wreg;
    logic             m2reg;
    logic [RF_AW-1:0] wn;
  } stage_t;

  localparam int STAGE_W = $bits(stage_t);

endpackage

// File: rtl/regfile_hazard_ctrl_hazard_fwd_sel.sv
// rtl/regfile_hazard_ctrl_hazard_fwd_sel.sv - per-operand match/priority encoder giving fwd code and load-use flag
module hazard_fwd_sel
  import regfile_hazard_ctrl_pkg::*;
(
  input  logic             use_x,
  input  logic [RF_AW-1:0] x,
  input  stage_t           ex,
  input  stage_t           mem,
  input  stage_t           wb,
  output logic [1:0]       fwd,
  output logic             lu
);

  logic live;
  logic ex_hit;
  logic mem_hit;
  logic wb_hit;

  assign live    = use_x & (x != '0);
  assign ex_hit  = live & ex.valid  & ex.wreg  & (ex.wn  == x);
  assign mem_hit = live & mem.valid & mem.wreg & (mem.wn == x);
  assign wb_hit  = live & wb.valid  & wb.wreg  & (wb.wn  == x);

  // A load in EX has no data yet; it blocks older stages and only raises the load-use flag.
  always_comb begin
    fwd = FWD_RF;
    if (ex_hit) begin
      if (!ex.m2reg) fwd = FWD_EX;
    end else if (mem_hit) begin
      fwd = FWD_MEM;
    end else if (wb_hit) begin
      fwd = FWD_WB;
    end
  end

  assign lu = ex_hit & ex.m2reg;

endmodule

// File: rtl/regfile_hazard_ctrl.sv
// rtl/regfile_hazard_ctrl.sv - EX/MEM/WB shadow pipeline, forwarding selects, load-use/mem-wait stall
// Optional stall_cnt output enabled by REGFILE_HAZARD_STALL_CNT_EN.
module regfile_hazard_ctrl
  import regfile_hazard_ctrl_pkg::*;
#(
  parameter int AW = RF_AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          id_valid,
  input  logic [AW-1:0] id_rs,
  input  logic [AW-1:0] id_rt,
  input  logic          id_use_rs,
  input  logic          id_use_rt,
  input  logic          id_wreg,
  input  logic [AW-1:0] id_wn,
  input  logic          id_m2reg,
  input  logic          flush,
  input  logic          mem_wait,
  output logic          stall,
  output logic [1:0]    fwda,
  output logic [1:0]    fwdb,
  output logic          rf_we,
  output logic [AW-1:0] rf_wn
`ifdef REGFILE_HAZARD_STALL_CNT_EN
  ,
  output logic [31:0]   stall_cnt
`endif
);

  stage_t ex_q;
  stage_t mem_q;
  stage_t wb_q;
  stage_t id_entry;
  logic   kill_pend;
  logic   lu_a;
  logic   lu_b;
  logic   lu_hazard;

  hazard_fwd_sel u_sel_rs (
    .use_x (id_use_rs),
    .x     (id_rs),
    .ex    (ex_q),
    .mem   (mem_q),
    .wb    (wb_q),
    .fwd   (fwda),
    .lu    (lu_a)
  );

  hazard_fwd_sel u_sel_rt (
    .use_x (id_use_rt),
    .x     (id_rt),
    .ex    (ex_q),
    .mem   (mem_q),
    .wb    (wb_q),
    .fwd   (fwdb),
    .lu    (lu_b)
  );

  assign lu_hazard = id_valid & ~flush & ~kill_pend & (lu_a | lu_b);
  assign stall     = lu_hazard | mem_wait;

  assign id_entry = '{valid: id_valid & ~flush & ~kill_pend,
                      wreg:  id_wreg,
                      m2reg: id_m2reg,
                      wn:    id_wn};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q      <= '0;
      mem_q     <= '0;
      wb_q      <= '0;
      kill_pend <= 1'b0;
    end else if (mem_wait) begin
      // MEM cannot retire, so WB sees bubbles; a flush now must still kill the held ID slot later.
      wb_q <= '0;
      if (flush) kill_pend <= 1'b1;
    end else if (lu_hazard) begin
      ex_q  <= '0;
      mem_q <= ex_q;
      wb_q  <= mem_q;
    end else begin
      ex_q      <= id_entry;
      mem_q     <= ex_q;
      wb_q      <= mem_q;
      kill_pend <= 1'b0;
    end
  end

  assign rf_we = wb_q.valid & wb_q.wreg & (wb_q.wn != '0);
  assign rf_wn = wb_q.wn;

`ifdef REGFILE_HAZARD_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_regfile_hazard_ctrl.sv
// tb/tb_regfile_hazard_ctrl.sv - scoreboard bench with a behavioural in-flight-writer model
module tb_regfile_hazard_ctrl;

  logic       clk;
  logic       rst_n;
  logic       id_valid;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_use_rs;
  logic       id_use_rt;
  logic       id_wreg;
  logic [4:0] id_wn;
  logic       id_m2reg;
  logic       flush;
  logic       mem_wait;
  logic       stall;
  logic [1:0] fwda;
  logic [1:0] fwdb;
  logic       rf_we;
  logic [4:0] rf_wn;
`ifdef REGFILE_HAZARD_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  regfile_hazard_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .id_valid  (id_valid),
    .id_rs     (id_rs),
    .id_rt     (id_rt),
    .id_use_rs (id_use_rs),
    .id_use_rt (id_use_rt),
    .id_wreg   (id_wreg),
    .id_wn     (id_wn),
    .id_m2reg  (id_m2reg),
    .flush     (flush),
    .mem_wait  (mem_wait),
    .stall     (stall),
    .fwda      (fwda),
    .fwdb      (fwdb),
    .rf_we     (rf_we),
    .rf_wn     (rf_wn)
`ifdef REGFILE_HAZARD_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // In-flight instructions, youngest first: 0 = EX, 1 = MEM, 2 = WB.
  typedef struct {
    bit v;
    bit w;
    bit l;
    int d;
  } ent_t;

  typedef struct {
    logic        stall;
    logic [1:0]  fa;
    logic [1:0]  fb;
    bit          ca;
    bit          cb;
    logic        we;
    logic [4:0]  wn;
    logic [31:0] cnt;
  } exp_t;

  ent_t    m[3];
  bit      kill;
  longint  cnt;
  exp_t    exp_q[$];
  int      checks;
  int      errors;
  bit      driver_done;
  bit      prev_stall;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic void model_reset();
    for (int s = 0; s < 3; s++) m[s] = '{v: 0, w: 0, l: 0, d: 0};
    kill = 0;
    cnt  = 0;
  endfunction

  // Newest in-flight writer of x wins; a load still in EX cannot supply data.
  function automatic void ref_fwd(input bit u, input int x, output int code,
                                  output bit chkd, output bit lu);
    code = 0;
    chkd = 1;
    lu   = 0;
    if (u && x != 0) begin
      for (int s = 0; s < 3; s++) begin
        if (m[s].v && m[s].w && m[s].d == x) begin
          if (s == 0 && m[s].l) begin
            chkd = 0;
            lu   = 1;
          end else begin
            code = s + 1;
          end
          break;
        end
      end
    end
  endfunction

  task automatic step(input bit v, input int rs, input int rt, input bit urs, input bit urt,
                      input bit wr, input int wn, input bit ld, input bit fl, input bit mw);
    exp_t e;
    int   ca, cb;
    bit   ka, kb, la, lb, lu;
    @(negedge clk);
    #1;
    rst_n     = 1'b1;
    id_valid  = v;
    id_rs     = 5'(rs);
    id_rt     = 5'(rt);
    id_use_rs = urs;
    id_use_rt = urt;
    id_wreg   = wr;
    id_wn     = 5'(wn);
    id_m2reg  = ld;
    flush     = fl;
    mem_wait  = mw;
    ref_fwd(urs, rs, ca, ka, la);
    ref_fwd(urt, rt, cb, kb, lb);
    lu      = v && !fl && !kill && (la || lb);
    e.stall = lu || mw;
    e.fa    = 2'(ca);
    e.fb    = 2'(cb);
    e.ca    = ka;
    e.cb    = kb;
    e.we    = m[2].v && m[2].w && m[2].d != 0;
    e.wn    = 5'(m[2].d);
    e.cnt   = 32'(cnt);
    exp_q.push_back(e);
    prev_stall = e.stall;
    if (e.stall && cnt != 64'hFFFF_FFFF) cnt++;
    if (mw) begin
      m[2] = '{v: 0, w: 0, l: 0, d: 0};
      if (fl) kill = 1;
    end else if (lu) begin
      m[2] = m[1];
      m[1] = m[0];
      m[0] = '{v: 0, w: 0, l: 0, d: 0};
    end else begin
      m[2] = m[1];
      m[1] = m[0];
      m[0] = '{v: v && !fl && !kill, w: wr, l: ld, d: wn};
      kill = 0;
    end
  endtask

  task automatic nop();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic check_reset_state();
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_fwda", 32'(fwda), 32'd0);
    chk("rst_fwdb", 32'(fwdb), 32'd0);
    chk("rst_rf_we", 32'(rf_we), 32'd0);
    chk("rst_rf_wn", 32'(rf_wn), 32'd0);
`ifdef REGFILE_HAZARD_STALL_CNT_EN
    chk("rst_stall_cnt", stall_cnt, 32'd0);
`endif
  endtask

  // Monitor: every cycle the DUT presents its combinational response, compare with the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("stall", 32'(stall), 32'(e.stall));
        if (e.ca) chk("fwda", 32'(fwda), 32'(e.fa));
        if (e.cb) chk("fwdb", 32'(fwdb), 32'(e.fb));
        chk("rf_we", 32'(rf_we), 32'(e.we));
        chk("rf_wn", 32'(rf_wn), 32'(e.wn));
`ifdef REGFILE_HAZARD_STALL_CNT_EN
        chk("stall_cnt", stall_cnt, e.cnt);
`endif
      end
    end
  end

  initial begin
    checks      = 0;
    errors      = 0;
    driver_done = 0;
    prev_stall  = 0;
    rst_n       = 1'b0;
    id_valid    = 0;
    id_rs       = '0;
    id_rt       = '0;
    id_use_rs   = 0;
    id_use_rt   = 0;
    id_wreg     = 0;
    id_wn       = '0;
    id_m2reg    = 0;
    flush       = 0;
    mem_wait    = 0;
    model_reset();
    #2;
    check_reset_state();

    // ALU back-to-back, then r0 filter
    step(1, 0, 0, 0, 0, 1, 3, 0, 0, 0);
    step(1, 3, 0, 1, 0, 1, 4, 0, 0, 0);
    step(1, 3, 4, 1, 1, 1, 0, 0, 0, 0);
    step(1, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    repeat (3) nop();
    // load-use, then distance-two load consumer
    step(1, 0, 0, 0, 0, 1, 5, 1, 0, 0);
    step(1, 0, 5, 0, 1, 1, 7, 0, 0, 0);
    step(1, 0, 5, 0, 1, 1, 7, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1, 6, 1, 0, 0);
    nop();
    step(1, 0, 6, 0, 1, 0, 0, 0, 0, 0);
    // mem_wait with a load in MEM, flush during the wait
    step(1, 0, 0, 0, 0, 1, 2, 1, 0, 0);
    step(1, 1, 1, 1, 1, 1, 1, 0, 0, 0);
    step(1, 2, 0, 1, 0, 1, 3, 0, 0, 1);
    step(1, 2, 0, 1, 0, 1, 3, 0, 1, 1);
    step(1, 2, 0, 1, 0, 1, 3, 0, 0, 1);
    step(1, 2, 0, 1, 0, 1, 3, 0, 0, 0);
    step(1, 3, 0, 1, 0, 1, 3, 0, 0, 0);
    repeat (3) nop();

    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        @(negedge clk);
        #1;
        rst_n    = 1'b0;
        mem_wait = 0;
        id_valid = 0;
        flush    = 0;
        #1;
        chk("async_rst_rf_we", 32'(rf_we), 32'd0);
`ifdef REGFILE_HAZARD_STALL_CNT_EN
        chk("async_rst_stall_cnt", stall_cnt, 32'd0);
`endif
        model_reset();
        prev_stall = 0;
      end
      if (prev_stall) begin
        step(id_valid, int'(id_rs), int'(id_rt), id_use_rs, id_use_rt, id_wreg, int'(id_wn),
             id_m2reg, ($urandom_range(0, 9) == 0), ($urandom_range(0, 6) == 0));
      end else begin
        step($urandom_range(0, 4) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3) != 0,
             $urandom_range(0, 3), $urandom_range(0, 2) == 0,
             ($urandom_range(0, 9) == 0), ($urandom_range(0, 6) == 0));
      end
    end
    driver_done = 1;
    repeat (2) @(negedge clk);
    #5;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
